aes_cipher_iter: RTL



---
 rtl/aes_cipher_iter_pkg.sv | 50 +++++
 rtl/aes_round.sv | 37 +++
 rtl/aes_cipher_iter.sv | 80 ++++++++
 3 files changed

// File: rtl/aes_cipher_iter_pkg.sv
// Shared AES-128 definitions: size defaults, FSM encoding, S-box, GF(2^8) doubling and
// byte-index helpers for the 128-bit column-major state.
package aes_cipher_iter_pkg;

   localparam int unsigned NbDef = 4;
   localparam int unsigned NkDef = 4;
   localparam int unsigned NrDef = 10;

   typedef enum logic {StIdle, StRun} fsm_e;

   // Forward S-box, entry 0 in the top byte.
   localparam logic [2047:0] SboxTable = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SboxTable[11'd2047 - {b, 3'b000} -: 8];
   endfunction

   // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // MSB position of state byte i; byte 0 sits in bits [127:120].
   function automatic int unsigned byte_msb(input int unsigned i);
      return 127 - 8 * i;
   endfunction

   // ShiftRows source: byte (row r, col c) takes the byte at (r, (c + r) mod 4).
   function automatic int unsigned shift_src(input int unsigned i);
      return (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
   endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
   import aes_cipher_iter_pkg::*;
(
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   input  logic         last,
   output logic [127:0] state_out
);

   logic [7:0] sb [16];
   logic [7:0] sr [16];
   logic [7:0] mc [16];

   for (genvar i = 0; i < 16; i++) begin : g_sub_shift
      assign sb[i] = sbox(state_in[byte_msb(i) -: 8]);
      assign sr[i] = sb[shift_src(i)];
   end

   for (genvar c = 0; c < 4; c++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr[4*c];
      assign a1 = sr[4*c+1];
      assign a2 = sr[4*c+2];
      assign a3 = sr[4*c+3];
      assign mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
   end

   // The final round has no MixColumns.
   for (genvar i = 0; i < 16; i++) begin : g_ark
      assign state_out[byte_msb(i) -: 8] = (last ? sr[i] : mc[i]) ^ round_key[byte_msb(i) -: 8];
   end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128 encryption: initial AddRoundKey on start, then one round per clock.
module aes_cipher_iter
   import aes_cipher_iter_pkg::*;
#(
   parameter int unsigned Nk = NkDef,
   parameter int unsigned Nr = NrDef,
   parameter int unsigned Nb = NbDef
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [127:0]              plain_in,
   input  logic [0:(Nr+1)*Nb*32-1]   key_sched,
   output logic                      ready,
   output logic                      done,
   output logic [127:0]              cipher_out
);

   if (Nk != 4 || Nr != 10 || Nb != 4) begin : g_bad_cfg
      $error("aes_cipher_iter supports only AES-128 (Nk=4, Nr=10, Nb=4)");
   end

   fsm_e         fsm_q;
   logic [127:0] state_q;
   logic [3:0]   rnd_q;
   logic [127:0] round_key;
   logic [127:0] round_out;
   logic         last_round;
   logic [127:0] keys [Nr+1];

   // Round r of the schedule starts at bit r*128, which is the MSB of its byte 0.
   for (genvar r = 0; r <= Nr; r++) begin : g_keys
      assign keys[r] = key_sched[r*Nb*32 +: Nb*32];
   end

   assign round_key  = keys[rnd_q];
   assign last_round = (rnd_q == 4'(Nr));

   aes_round u_round (
      .state_in  (state_q),
      .round_key (round_key),
      .last      (last_round),
      .state_out (round_out)
   );

   // FSM, round counter, state and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q      <= StIdle;
         state_q    <= '0;
         rnd_q      <= '0;
         cipher_out <= '0;
         done       <= 1'b0;
         ready      <= 1'b1;
      end else begin
         done <= 1'b0;
         unique case (fsm_q)
            StIdle: begin
               if (start) begin
                  state_q <= plain_in ^ keys[0];
                  rnd_q   <= 4'd1;
                  ready   <= 1'b0;
                  fsm_q   <= StRun;
               end
            end
            StRun: begin
               state_q <= round_out;
               rnd_q   <= rnd_q + 4'd1;
               if (last_round) begin
                  cipher_out <= round_out;
                  done       <= 1'b1;
                  ready      <= 1'b1;
                  fsm_q      <= StIdle;
               end
            end
         endcase
      end
   end

endmodule
